fpu_cvt_unpack: RTL and testbench
=================================

Name: fpu_cvt_unpack

Overview:
- Upstream operand stage for the float-to-integer converter (FCVT.W.S / FCVT.WU.S).
- Accepts a raw IEEE-754 single-precision operand with the instruction's rounding mode, and resolves the dynamic rounding mode against frm.
- Classifies the operand (NaN, Inf, zero, subnormal) and unpacks it into sign / biased exponent / 24-bit significand fields.
- Presents the result through a registered valid/ready pipeline stage with a 2-entry skid buffer, so the converter sees fully registered inputs.

Parameters:
- TAG_W, 5, width of the opaque tag (destination register index) carried alongside the operand.

Ports:
- clk_i  input  1  core clock.
- reset_i  input  1  asynchronous reset, active-low.
- flush_i  input  1  synchronous pipeline flush; drops all held entries.
- in_valid_i  input  1  upstream operand valid.
- in_ready_o  output  1  stage can accept this cycle.
- op_i  input  32  raw single-precision operand.
- is_unsigned_i  input  1  1 = FCVT.WU.S, 0 = FCVT.W.S.
- rm_i  input  3  instruction rm field.
- frm_i  input  3  frm CSR value.
- tag_i  input  TAG_W  passthrough tag.
- out_valid_o  output  1  converter payload valid.
- out_ready_i  input  1  converter accepts payload.
- is_unsigned_o  output  1  registered copy of is_unsigned_i.
- is_exp_neg_o  output  1  unbiased exponent < 0 (|x| < 1.0, includes zero and subnormals).
- rounding_mode_o  output  3  resolved rounding mode.
- illegal_rm_o  output  1  resolved rounding mode is 101, 110 or 111.
- isNaN_o  output  1  operand is NaN (quiet or signalling).
- isSNaN_o  output  1  operand is a signalling NaN.
- isInf_o  output  1  operand is infinity.
- isZero_o  output  1  operand is +/-0.
- sign_o  output  1  sign bit.
- exp_o  output  8  biased exponent (see unpack rules).
- sig_o  output  24  significand including hidden bit.
- tag_o  output  TAG_W  tag.

Behaviour:
- Reset (reset_i low, asynchronous): both entries invalid; out_valid_o=0, in_ready_o=1; all payload outputs 0.
- Accept: occurs when in_valid_i && in_ready_o at a rising edge. Latency is 1 cycle: an accepted operand appears on out_valid_o at the next edge when the stage is empty or draining.
- Storage: a main register drives the outputs; a skid register is behind it.
  - in_ready_o is registered and equals "skid register empty".
  - Accept while the main register is holding and out_ready_i=0: the operand goes to the skid register and in_ready_o drops the next cycle.
  - Main register transfers (out_valid_o && out_ready_i): the skid entry, if any, moves to main and in_ready_o rises the next cycle.
  - Simultaneous accept and transfer with the skid register empty: the new operand loads main directly.
  - Strict FIFO order; no entry is lost or duplicated.
  - Payload stays stable while out_valid_o=1 and out_ready_i=0.
- Flush: flush_i=1 at an edge clears both valid bits and sets in_ready_o=1. An accept in the same cycle is discarded. Flush has priority over transfer.
- Rounding-mode resolution (at accept):
  - rm_i=111: resolved mode = frm_i. Otherwise resolved mode = rm_i.
  - illegal_rm_o=1 if the resolved mode is 101, 110 or 111. The payload is still forwarded; the downstream converter/decoder raises the illegal-instruction exception.
- Unpack (at accept), with e=op_i[30:23], f=op_i[22:0]:
  - sign_o = op_i[31].
  - e=255, f!=0: isNaN=1; isSNaN = ~f[22].
  - e=255, f=0: isInf=1.
  - e=0, f=0: isZero=1, exp_o=0, sig_o=0.
  - e=0, f!=0 (subnormal): exp_o=1, sig_o={1'b0,f}.
  - Normal: exp_o=e, sig_o={1'b1,f}.
  - is_exp_neg_o = (exp_o < 127).
  - For NaN/Inf, exp_o=255 and sig_o={1'b1,f} (don't-care downstream).
- Only isNaN_o, isInf_o and isZero_o are mutually exclusive.
- No combinational path from out_ready_i to in_ready_o.

Decomposition:
- Shared package holds:
  - the rounding-mode encodings (RNE=000, RTZ=001, RDN=010, RUP=011, RMM=100, DYN=111);
  - the constants EXP_BIAS=127 and EXP_MAX=255;
  - a packed payload struct {is_unsigned, rm, illegal_rm, isNaN, isSNaN, isInf, isZero, sign, exp, sig, tag} reused by both storage registers.
- One natural sub-module: fpu_sp_classify, the combinational unpack/classify of a 32-bit operand, reusable by other FPU front ends.

Test Plan:
- 0x3F800000 (1.0), rm=000, out_ready=1 -> next cycle out_valid=1, sign=0, exp=127, sig=0x800000, is_exp_neg=0, all class flags 0, rounding_mode=000.
- 0x00000001 subnormal, rm=111, frm=011 -> exp=1, sig=0x000001, is_exp_neg=1, rounding_mode=011, illegal_rm=0. Also 0x7F800001 -> isNaN=1, isSNaN=1. Also 0xFF800000 -> isInf=1, sign=1.
- rm=111 with frm=101 -> rounding_mode=101, illegal_rm=1, payload still delivered.
- Backpressure:
  - out_ready=0, push A, B, C back-to-back -> A accepted into main, B into skid, in_ready=0 when C is offered (C held upstream).
  - Then out_ready=1 -> A, B, C exit in order, one per cycle, with in_ready returning to 1 one cycle after A transfers.
- flush_i pulsed with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed operand never appears.
- reset_i asserted low mid-transfer (asynchronously, between edges) -> out_valid=0, in_ready=1 immediately. After release, first accepted operand emerges with 1-cycle latency.

Source files
------------

// File: rtl/fpu_cvt_unpack_pkg.sv
// Shared types and constants for the float-to-integer converter front end.
// The payload struct is the unit stored in both the main and skid registers.
package fpu_cvt_unpack_pkg;

    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100,
        RM_DYN = 3'b111
    } rm_e;

    localparam logic [7:0] EXP_BIAS = 8'd127;
    localparam logic [7:0] EXP_MAX  = 8'd255;

    // Tag width held in the payload; the top-level TAG_W must not exceed it.
    localparam int PAYLOAD_TAG_W = 5;

    typedef struct packed {
        logic                     is_unsigned;
        logic [2:0]               rm;
        logic                     illegal_rm;
        logic                     isNaN;
        logic                     isSNaN;
        logic                     isInf;
        logic                     isZero;
        logic                     sign;
        logic [7:0]               exp;
        logic [23:0]              sig;
        logic [PAYLOAD_TAG_W-1:0] tag;
    } payload_t;

    // 101, 110 and 111 have no static meaning once DYN has been resolved.
    function automatic logic is_illegal_rm(input logic [2:0] rm);
        return (rm == 3'b101) || (rm == 3'b110) || (rm == 3'b111);
    endfunction

endpackage

// File: rtl/fpu_sp_classify.sv
// Combinational classify/unpack of an IEEE-754 single-precision operand.
// Subnormals are reported with exponent 1 so the significand needs no extra shift.
module fpu_sp_classify
    import fpu_cvt_unpack_pkg::*;
(
    input  logic [31:0] op,
    output logic        sign,
    output logic        is_nan,
    output logic        is_snan,
    output logic        is_inf,
    output logic        is_zero,
    output logic [7:0]  exp,
    output logic [23:0] sig
);

    logic [7:0]  exp_field;
    logic [22:0] frac_field;
    logic        exp_ones;
    logic        exp_zero;
    logic        frac_zero;

    assign exp_field  = op[30:23];
    assign frac_field = op[22:0];
    assign exp_ones   = (exp_field == EXP_MAX);
    assign exp_zero   = (exp_field == 8'd0);
    assign frac_zero  = (frac_field == 23'd0);

    assign sign    = op[31];
    assign is_nan  = exp_ones & ~frac_zero;
    assign is_snan = is_nan & ~frac_field[22];
    assign is_inf  = exp_ones & frac_zero;
    assign is_zero = exp_zero & frac_zero;

    always_comb begin
        exp = exp_field;
        sig = {1'b1, frac_field};
        if (is_zero) begin
            exp = 8'd0;
            sig = 24'd0;
        end else if (exp_zero) begin
            exp = 8'd1;
            sig = {1'b0, frac_field};
        end
    end

endmodule

// File: rtl/fpu_cvt_unpack.sv
// Operand stage for FCVT.W[U].S: resolves rounding mode, unpacks the operand and
// presents it through a registered valid/ready stage backed by a skid register.
module fpu_cvt_unpack
    import fpu_cvt_unpack_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      op_i,
    input  logic             is_unsigned_i,
    input  logic [2:0]       rm_i,
    input  logic [2:0]       frm_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             is_unsigned_o,
    output logic             is_exp_neg_o,
    output logic [2:0]       rounding_mode_o,
    output logic             illegal_rm_o,
    output logic             isNaN_o,
    output logic             isSNaN_o,
    output logic             isInf_o,
    output logic             isZero_o,
    output logic             sign_o,
    output logic [7:0]       exp_o,
    output logic [23:0]      sig_o,
    output logic [TAG_W-1:0] tag_o
);

    payload_t   in_payload;
    payload_t   main_reg, main_next;
    payload_t   skid_reg, skid_next;
    logic       main_valid_reg, main_valid_next;
    logic       skid_valid_reg, skid_valid_next;
    logic       ready_reg;
    logic [2:0] rm_resolved;
    logic       accept;
    logic       transfer;

    fpu_sp_classify u_classify (
        .op      (op_i),
        .sign    (in_payload.sign),
        .is_nan  (in_payload.isNaN),
        .is_snan (in_payload.isSNaN),
        .is_inf  (in_payload.isInf),
        .is_zero (in_payload.isZero),
        .exp     (in_payload.exp),
        .sig     (in_payload.sig)
    );

    assign rm_resolved            = (rm_i == RM_DYN) ? frm_i : rm_i;
    assign in_payload.is_unsigned = is_unsigned_i;
    assign in_payload.rm          = rm_resolved;
    assign in_payload.illegal_rm  = is_illegal_rm(rm_resolved);
    assign in_payload.tag         = PAYLOAD_TAG_W'(tag_i);

    assign accept   = in_valid_i & ready_reg;
    assign transfer = main_valid_reg & out_ready_i;

    // Accept is only possible with the skid empty, so a skid entry never
    // competes with a new operand for the main register.
    always_comb begin
        main_next       = main_reg;
        skid_next       = skid_reg;
        main_valid_next = main_valid_reg;
        skid_valid_next = skid_valid_reg;
        if (flush_i) begin
            main_valid_next = 1'b0;
            skid_valid_next = 1'b0;
        end else if (!main_valid_reg || transfer) begin
            if (skid_valid_reg) begin
                main_next       = skid_reg;
                main_valid_next = 1'b1;
                skid_valid_next = 1'b0;
            end else if (accept) begin
                main_next       = in_payload;
                main_valid_next = 1'b1;
            end else begin
                main_valid_next = 1'b0;
            end
        end else if (accept) begin
            skid_next       = in_payload;
            skid_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            main_reg       <= '0;
            skid_reg       <= '0;
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
            ready_reg      <= 1'b1;
        end else begin
            main_reg       <= main_next;
            skid_reg       <= skid_next;
            main_valid_reg <= main_valid_next;
            skid_valid_reg <= skid_valid_next;
            ready_reg      <= ~skid_valid_next;
        end
    end

    assign in_ready_o      = ready_reg;
    assign out_valid_o     = main_valid_reg;
    assign is_unsigned_o   = main_reg.is_unsigned;
    // Gated with valid so an idle stage (exp=0) presents all-zero outputs.
    assign is_exp_neg_o    = main_valid_reg & (main_reg.exp < EXP_BIAS);
    assign rounding_mode_o = main_reg.rm;
    assign illegal_rm_o    = main_reg.illegal_rm;
    assign isNaN_o         = main_reg.isNaN;
    assign isSNaN_o        = main_reg.isSNaN;
    assign isInf_o         = main_reg.isInf;
    assign isZero_o        = main_reg.isZero;
    assign sign_o          = main_reg.sign;
    assign exp_o           = main_reg.exp;
    assign sig_o           = main_reg.sig;
    assign tag_o           = TAG_W'(main_reg.tag);

endmodule

// File: tb/tb_fpu_cvt_unpack.sv
// Directed bench for fpu_cvt_unpack: classify vectors, rounding-mode resolution,
// skid backpressure ordering, flush and asynchronous reset.
module tb_fpu_cvt_unpack;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] op_i;
    logic        is_unsigned_i;
    logic [2:0]  rm_i;
    logic [2:0]  frm_i;
    logic [4:0]  tag_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic        is_unsigned_o;
    logic        is_exp_neg_o;
    logic [2:0]  rounding_mode_o;
    logic        illegal_rm_o;
    logic        isNaN_o;
    logic        isSNaN_o;
    logic        isInf_o;
    logic        isZero_o;
    logic        sign_o;
    logic [7:0]  exp_o;
    logic [23:0] sig_o;
    logic [4:0]  tag_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    fpu_cvt_unpack #(.TAG_W(5)) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .flush_i         (flush_i),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .op_i            (op_i),
        .is_unsigned_i   (is_unsigned_i),
        .rm_i            (rm_i),
        .frm_i           (frm_i),
        .tag_i           (tag_i),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .is_unsigned_o   (is_unsigned_o),
        .is_exp_neg_o    (is_exp_neg_o),
        .rounding_mode_o (rounding_mode_o),
        .illegal_rm_o    (illegal_rm_o),
        .isNaN_o         (isNaN_o),
        .isSNaN_o        (isSNaN_o),
        .isInf_o         (isInf_o),
        .isZero_o        (isZero_o),
        .sign_o          (sign_o),
        .exp_o           (exp_o),
        .sig_o           (sig_o),
        .tag_o           (tag_o)
    );

    // Flag vector order: {is_exp_neg, isNaN, isSNaN, isInf, isZero, illegal_rm}
    function automatic logic [5:0] flags();
        return {is_exp_neg_o, isNaN_o, isSNaN_o, isInf_o, isZero_o, illegal_rm_o};
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [31:0] op, input logic [2:0] rm, input logic [2:0] frm,
                         input logic uns, input logic [4:0] tag);
        in_valid_i    = 1'b1;
        op_i          = op;
        rm_i          = rm;
        frm_i         = frm;
        is_unsigned_i = uns;
        tag_i         = tag;
    endtask

    task automatic test_reset();
        reset_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        op_i = '0; rm_i = '0; frm_i = '0; is_unsigned_i = 1'b0; tag_i = '0;
        #12;
        checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid_o); end
        checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready_o); end
        checks++; if ({exp_o, sig_o, tag_o, rounding_mode_o, sign_o, is_unsigned_o, flags()} !== '0) begin
            failures++; $display("FAIL reset_payload exp=%h sig=%h tag=%h rm=%b flags=%b want all zero", exp_o, sig_o, tag_o, rounding_mode_o, flags());
        end
        @(negedge clk_i);
        reset_i = 1'b1;
        step();
        $display("reset: out_valid=%b in_ready=%b", out_valid_o, in_ready_o);
    endtask

    task automatic test_normal();
        drive(32'h3F80_0000, 3'b000, 3'b010, 1'b0, 5'd3);
        step();
        in_valid_i = 1'b0;
        $display("normal 1.0: valid=%b exp=%h sig=%h flags=%b rm=%b", out_valid_o, exp_o, sig_o, flags(), rounding_mode_o);
        checks++; if (out_valid_o !== 1'b1) begin failures++; $display("FAIL normal_valid got=%b want=1", out_valid_o); end
        checks++; if ({sign_o, exp_o, sig_o} !== {1'b0, 8'd127, 24'h800000}) begin
            failures++; $display("FAIL normal_fields got sign=%b exp=%h sig=%h want 0/7f/800000", sign_o, exp_o, sig_o);
        end
        checks++; if ({flags(), rounding_mode_o, tag_o} !== {6'b000000, 3'b000, 5'd3}) begin
            failures++; $display("FAIL normal_flags got flags=%b rm=%b tag=%h want 000000/000/03", flags(), rounding_mode_o, tag_o);
        end
        step();
        checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL normal_drain got=%b want=0", out_valid_o); end
    endtask

    typedef struct {
        logic [31:0] op;
        logic [2:0]  rm;
        logic [2:0]  frm;
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] sig;
        logic [5:0]  flg;
        logic [2:0]  rmode;
    } vec_t;

    // Back-to-back stream, one result per cycle.
    task automatic run_table(input string name, input vec_t v[]);
        for (int i = 0; i < v.size(); i++) begin
            drive(v[i].op, v[i].rm, v[i].frm, i[0], 5'(i + 8));
            step();
            $display("%s[%0d] op=%h: valid=%b sign=%b exp=%h sig=%h flags=%b rm=%b tag=%h",
                     name, i, v[i].op, out_valid_o, sign_o, exp_o, sig_o, flags(), rounding_mode_o, tag_o);
            checks++;
            if ({out_valid_o, sign_o, exp_o, sig_o, flags(), rounding_mode_o, is_unsigned_o, tag_o} !==
                {1'b1, v[i].sign, v[i].exp, v[i].sig, v[i].flg, v[i].rmode, i[0], 5'(i + 8)}) begin
                failures++;
                $display("FAIL %s[%0d] got v=%b s=%b e=%h m=%h f=%b rm=%b u=%b t=%h want s=%b e=%h m=%h f=%b rm=%b u=%b t=%h",
                         name, i, out_valid_o, sign_o, exp_o, sig_o, flags(), rounding_mode_o, is_unsigned_o, tag_o,
                         v[i].sign, v[i].exp, v[i].sig, v[i].flg, v[i].rmode, i[0], 5'(i + 8));
            end
        end
        in_valid_i = 1'b0;
        step();
    endtask

    task automatic test_classify();
        vec_t v[] = '{
            '{32'h0000_0001, 3'b111, 3'b011, 1'b0, 8'h01, 24'h000001, 6'b100000, 3'b011},
            '{32'h7F80_0001, 3'b000, 3'b000, 1'b0, 8'hFF, 24'h800001, 6'b011000, 3'b000},
            '{32'h7FC0_0000, 3'b001, 3'b000, 1'b0, 8'hFF, 24'hC00000, 6'b010000, 3'b001},
            '{32'hFF80_0000, 3'b010, 3'b000, 1'b1, 8'hFF, 24'h800000, 6'b000100, 3'b010},
            '{32'h8000_0000, 3'b011, 3'b000, 1'b1, 8'h00, 24'h000000, 6'b100010, 3'b011},
            '{32'h3F00_0000, 3'b100, 3'b000, 1'b0, 8'h7E, 24'h800000, 6'b100000, 3'b100},
            '{32'h4B00_0000, 3'b000, 3'b000, 1'b0, 8'h96, 24'h800000, 6'b000000, 3'b000},
            '{32'h807F_FFFF, 3'b000, 3'b000, 1'b1, 8'h01, 24'h7FFFFF, 6'b100000, 3'b000}
        };
        run_table("classify", v);
    endtask

    task automatic test_rounding_mode();
        vec_t v[] = '{
            '{32'h3F80_0000, 3'b111, 3'b101, 1'b0, 8'h7F, 24'h800000, 6'b000001, 3'b101},
            '{32'h3F80_0000, 3'b110, 3'b000, 1'b0, 8'h7F, 24'h800000, 6'b000001, 3'b110},
            '{32'h3F80_0000, 3'b111, 3'b111, 1'b0, 8'h7F, 24'h800000, 6'b000001, 3'b111},
            '{32'h3F80_0000, 3'b111, 3'b100, 1'b0, 8'h7F, 24'h800000, 6'b000000, 3'b100},
            '{32'h3F80_0000, 3'b101, 3'b001, 1'b0, 8'h7F, 24'h800000, 6'b000001, 3'b101}
        };
        run_table("rmode", v);
    endtask

    task automatic test_back_to_back();
        out_ready_i = 1'b0;
        drive(32'h4000_0000, 3'b000, 3'b000, 1'b0, 5'd1);   // A = 2.0
        step();
        drive(32'h4040_0000, 3'b000, 3'b000, 1'b0, 5'd2);   // B = 3.0
        checks++; if ({out_valid_o, in_ready_o, tag_o} !== {1'b1, 1'b1, 5'd1}) begin
            failures++; $display("FAIL bp_A_main got v=%b r=%b t=%h want 1/1/01", out_valid_o, in_ready_o, tag_o);
        end
        step();
        drive(32'h4080_0000, 3'b000, 3'b000, 1'b0, 5'd3);   // C = 4.0
        $display("bp: B skidded, v=%b r=%b tag=%h", out_valid_o, in_ready_o, tag_o);
        checks++; if ({out_valid_o, in_ready_o, tag_o, exp_o} !== {1'b1, 1'b0, 5'd1, 8'h80}) begin
            failures++; $display("FAIL bp_B_skid got v=%b r=%b t=%h e=%h want 1/0/01/80", out_valid_o, in_ready_o, tag_o, exp_o);
        end
        step();
        checks++; if ({out_valid_o, in_ready_o, tag_o} !== {1'b1, 1'b0, 5'd1}) begin
            failures++; $display("FAIL bp_C_held got v=%b r=%b t=%h want 1/0/01", out_valid_o, in_ready_o, tag_o);
        end
        out_ready_i = 1'b1;
        step();
        $display("bp: A out, v=%b r=%b tag=%h", out_valid_o, in_ready_o, tag_o);
        checks++; if ({out_valid_o, in_ready_o, tag_o, exp_o} !== {1'b1, 1'b1, 5'd2, 8'h80}) begin
            failures++; $display("FAIL bp_B_out got v=%b r=%b t=%h e=%h want 1/1/02/80", out_valid_o, in_ready_o, tag_o, exp_o);
        end
        step();
        in_valid_i = 1'b0;
        $display("bp: B out, v=%b r=%b tag=%h", out_valid_o, in_ready_o, tag_o);
        checks++; if ({out_valid_o, tag_o, exp_o} !== {1'b1, 5'd3, 8'h81}) begin
            failures++; $display("FAIL bp_C_out got v=%b t=%h e=%h want 1/03/81", out_valid_o, tag_o, exp_o);
        end
        step();
        checks++; if ({out_valid_o, in_ready_o} !== 2'b01) begin
            failures++; $display("FAIL bp_empty got v=%b r=%b want 0/1", out_valid_o, in_ready_o);
        end
    endtask

    task automatic test_flush();
        out_ready_i = 1'b0;
        drive(32'h4000_0000, 3'b000, 3'b000, 1'b0, 5'd4);
        step();
        drive(32'h4040_0000, 3'b000, 3'b000, 1'b0, 5'd5);
        step();
        drive(32'h4080_0000, 3'b000, 3'b000, 1'b0, 5'd6);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        $display("flush full: v=%b r=%b", out_valid_o, in_ready_o);
        checks++; if ({out_valid_o, in_ready_o} !== 2'b01) begin
            failures++; $display("FAIL flush_full got v=%b r=%b want 0/1", out_valid_o, in_ready_o);
        end
        // Flush coinciding with an accept into an empty stage discards it.
        drive(32'h40A0_0000, 3'b000, 3'b000, 1'b0, 5'd7);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        checks++; if (out_valid_o !== 1'b0) begin
            failures++; $display("FAIL flush_accept got v=%b t=%h want v=0", out_valid_o, tag_o);
        end
        out_ready_i = 1'b1;
        drive(32'h40C0_0000, 3'b000, 3'b000, 1'b0, 5'd9);
        step();
        in_valid_i = 1'b0;
        $display("after flush: v=%b tag=%h", out_valid_o, tag_o);
        checks++; if ({out_valid_o, tag_o} !== {1'b1, 5'd9}) begin
            failures++; $display("FAIL flush_next got v=%b t=%h want 1/09", out_valid_o, tag_o);
        end
        step();
    endtask

    task automatic test_async_reset();
        out_ready_i = 1'b0;
        drive(32'h4000_0000, 3'b000, 3'b000, 1'b0, 5'd10);
        step();
        drive(32'h4040_0000, 3'b000, 3'b000, 1'b0, 5'd11);
        out_ready_i = 1'b1;
        #3;
        reset_i = 1'b0;
        #1;
        in_valid_i = 1'b0;
        $display("async reset: v=%b r=%b", out_valid_o, in_ready_o);
        checks++; if ({out_valid_o, in_ready_o, tag_o, exp_o} !== {1'b0, 1'b1, 5'd0, 8'd0}) begin
            failures++; $display("FAIL async_reset got v=%b r=%b t=%h e=%h want 0/1/00/00", out_valid_o, in_ready_o, tag_o, exp_o);
        end
        #2;
        reset_i = 1'b1;
        drive(32'h4100_0000, 3'b000, 3'b000, 1'b1, 5'd12);
        step();
        in_valid_i = 1'b0;
        $display("post reset: v=%b tag=%h exp=%h", out_valid_o, tag_o, exp_o);
        checks++; if ({out_valid_o, tag_o, exp_o, is_unsigned_o} !== {1'b1, 5'd12, 8'h82, 1'b1}) begin
            failures++; $display("FAIL post_reset got v=%b t=%h e=%h u=%b want 1/0c/82/1", out_valid_o, tag_o, exp_o, is_unsigned_o);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_normal();
        test_classify();
        test_rounding_mode();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
